// File: rtl/bayer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bayer_pkg
// Brief    : Shared types and helpers for the 2x2 Bayer window streamer.
// Revision : 1.0
// ============================================================================
package bayer_pkg;

  localparam int DEF_PIX_W = 8;

  typedef struct packed {
    logic [DEF_PIX_W-1:0] ul;
    logic [DEF_PIX_W-1:0] up;
    logic [DEF_PIX_W-1:0] left;
    logic [DEF_PIX_W-1:0] cur;
  } win_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // RGGB phase of a pixel: {row parity, col parity}; 2'b00 is the R site.
  function automatic logic [1:0] rggb_phase(input logic row_lsb, input logic col_lsb);
    return {row_lsb, col_lsb};
  endfunction

  function automatic logic is_red_site(input logic row_lsb, input logic col_lsb);
    return (rggb_phase(row_lsb, col_lsb) == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_ram
// Brief    : DEPTH x PIX_W single-port line buffer, async read returns the
//            pre-write contents when the same address is written this cycle.
// Revision : 1.0
// ============================================================================
module line_buffer_ram #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/bayer_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : bayer_window_streamer
// Brief    : Raster-order 2x2 Bayer window generator with one-line buffer and
//            a single registered output stage. Define BORDER_REPLICATE_EN to
//            emit a window for every pixel using edge replication.
// Revision : 1.0
// ============================================================================
module bayer_window_streamer
  import bayer_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int MAX_W = 4096,
  parameter int DIM_W = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   image_width,
  input  logic [DIM_W-1:0]   image_height,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*PIX_W-1:0] out_win,
  output logic               out_row_par,
  output logic               out_col_par,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               err_cfg
);

  localparam int CW = $clog2(MAX_W) + 1;
  localparam int AW = $clog2(MAX_W);
  localparam logic [DIM_W:0] MAX_W_EXT = (DIM_W + 1)'(MAX_W);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    col;
  logic [CW-1:0]    width_m1;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] height_m1;
  logic [PIX_W-1:0] lb_rd;
  logic [PIX_W-1:0] left_q;
  logic [PIX_W-1:0] ul_q;
  logic [PIX_W-1:0] win_ul;
  logic [PIX_W-1:0] win_up;
  logic [PIX_W-1:0] win_left;
  logic             accept;
  logic             emit;
  logic             last_pix;
  logic             cfg_ok;
  logic             out_fire;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_pix = (row == height_m1) && (col == width_m1);
  assign busy     = (state != IDLE);
  assign cfg_ok   = (image_width >= DIM_W'(2)) &&
                    (image_height >= DIM_W'(2)) &&
                    ({1'b0, image_width} <= MAX_W_EXT);

  line_buffer_ram #(
    .PIX_W (PIX_W),
    .DEPTH (MAX_W),
    .AW    (AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (accept),
    .addr  (col[AW-1:0]),
    .wdata (in_data),
    .rdata (lb_rd)
  );

`ifdef BORDER_REPLICATE_EN
  // Missing neighbours on row 0 / col 0 are replaced by their in-frame mirror.
  always_comb begin
    win_up   = (row == '0) ? in_data : lb_rd;
    win_left = (col == '0) ? in_data : left_q;
    if (row == '0) begin
      win_ul = win_left;
    end else if (col == '0) begin
      win_ul = win_up;
    end else begin
      win_ul = ul_q;
    end
  end
  assign emit = 1'b1;
`else
  assign win_up   = lb_rd;
  assign win_left = left_q;
  assign win_ul   = ul_q;
  assign emit     = (row != '0) && (col != '0);
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && cfg_ok)         state_next = RUN;
      RUN:     if (accept && last_pix)      state_next = FLUSH;
      FLUSH:   if (out_fire && out_last)    state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      width_m1  <= '0;
      height_m1 <= '0;
      left_q    <= '0;
      ul_q      <= '0;
      err_cfg   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == FLUSH) && out_fire && out_last;
      if ((state == IDLE) && start) begin
        err_cfg <= !cfg_ok;
        if (cfg_ok) begin
          width_m1  <= CW'(image_width - DIM_W'(1));
          height_m1 <= image_height - DIM_W'(1);
          col       <= '0;
          row       <= '0;
        end
      end else if (accept) begin
        left_q <= in_data;
        ul_q   <= lb_rd;
        // Counters freeze on the final pixel so they can never wrap.
        if (!last_pix) begin
          if (col == width_m1) begin
            col <= '0;
            row <= row + DIM_W'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_win     <= '0;
      out_row_par <= 1'b0;
      out_col_par <= 1'b0;
      out_last    <= 1'b0;
    end else if (accept && emit) begin
      out_valid                  <= 1'b1;
      out_win                    <= {win_ul, win_up, win_left, in_data};
      {out_row_par, out_col_par} <= rggb_phase(row[0], col[0]);
      out_last                   <= last_pix;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bayer_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bayer_window_streamer
// Brief    : Directed self-checking bench for bayer_window_streamer.
// Revision : 1.0
// ============================================================================
module tb_bayer_window_streamer;
  import bayer_pkg::*;

  localparam int PIX_W = 8;
  localparam int MAX_W = 4096;
  localparam int DIM_W = 13;
`ifdef BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [DIM_W-1:0]   image_width;
  logic [DIM_W-1:0]   image_height;
  logic               in_valid;
  logic [PIX_W-1:0]   in_data;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [4*PIX_W-1:0] out_win;
  logic               out_row_par;
  logic               out_col_par;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               err_cfg;

  int tests = 0;
  int fails = 0;
  logic [7:0]  frame [0:2*MAX_W-1];
  logic [31:0] cap [$];

  always #5 clk = ~clk;

  bayer_window_streamer #(.PIX_W(PIX_W), .MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .image_width(image_width), .image_height(image_height),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
    .out_row_par(out_row_par), .out_col_par(out_col_par), .out_last(out_last),
    .busy(busy), .done(done), .err_cfg(err_cfg)
  );

  function automatic void fill_pattern(input int w, input int h);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        frame[j*w+i] = 8'(16*j + i);
  endfunction

  // Expected k-th window from the frame contents and the window definition.
  function automatic void exp_at(input int k, input int w, input int h,
                                 output logic [31:0] win, output logic rp,
                                 output logic cp, output logic lst);
    int j, i;
    logic [7:0] c, u, l, ul;
    if (BORDER) begin
      j = k / w;       i = k % w;
    end else begin
      j = 1 + k/(w-1); i = 1 + k%(w-1);
    end
    c  = frame[j*w+i];
    u  = (j == 0) ? c : frame[(j-1)*w+i];
    l  = (i == 0) ? c : frame[j*w+i-1];
    ul = (j == 0) ? l : ((i == 0) ? u : frame[(j-1)*w+i-1]);
    win = {ul, u, l, c};
    rp  = j[0];
    cp  = i[0];
    lst = (j == h-1) && (i == w-1);
  endfunction

  task automatic run_frame(input int w, input int h, input bit stall,
                           input bit poke_start, output int nwin);
    int pix, k, budget;
    bit prev_stall, last_seen, finished;
    logic [31:0] prev_win, ew;
    logic erp, ecp, elst;
    pix = 0; k = 0; prev_stall = 0; last_seen = 0; finished = 0;
    prev_win = '0;
    budget = w*h*3 + 100;
    cap.delete();
    @(negedge clk);
    image_width = DIM_W'(w); image_height = DIM_W'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || err_cfg !== 1'b0) begin
      fails++;
      $display("FAIL start_accept: busy=%0b err_cfg=%0b required busy=1 err_cfg=0", busy, err_cfg);
    end
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_start && cyc == 3) begin
        start = 1'b1; image_width = DIM_W'(1); image_height = DIM_W'(1);
      end
      out_ready = stall ? (cyc[0] == 1'b0) : 1'b1;
      in_valid  = (pix < w*h);
      in_data   = in_valid ? frame[pix] : 8'h00;
      #1;
      if (last_seen) begin
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          fails++;
          $display("FAIL done_after_last: done=%0b busy=%0b required done=1 busy=0", done, busy);
        end
        finished = 1;
      end else begin
        tests++;
        if (done !== 1'b0) begin
          fails++;
          $display("FAIL early_done: done=%0b required 0 at window %0d", done, k);
        end
        if (prev_stall) begin
          tests++;
          if (out_valid !== 1'b1 || out_win !== prev_win) begin
            fails++;
            $display("FAIL stall_hold: valid=%0b win=%h required valid=1 win=%h", out_valid, out_win, prev_win);
          end
        end
        if (out_valid && out_ready) begin
          exp_at(k, w, h, ew, erp, ecp, elst);
          tests++;
          if ({out_win, out_row_par, out_col_par, out_last} !== {ew, erp, ecp, elst}) begin
            fails++;
            $display("FAIL window_%0d: win=%h rp=%0b cp=%0b last=%0b required win=%h rp=%0b cp=%0b last=%0b",
                     k, out_win, out_row_par, out_col_par, out_last, ew, erp, ecp, elst);
          end
          cap.push_back(out_win);
          k++;
          if (out_last) last_seen = 1;
        end
        prev_stall = out_valid && !out_ready;
        prev_win   = out_win;
        if (in_valid && in_ready) pix++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    tests++;
    if (!finished) begin
      fails++;
      $display("FAIL frame_timeout: windows=%0d pixels=%0d required frame completion", k, pix);
    end
    nwin = k;
  endtask

  task automatic check_4x3(input int n, input string tag);
    win_t first_exp, last_exp, c10_exp;
    logic [31:0] got;
    last_exp = '{ul: 8'h12, up: 8'h13, left: 8'h22, cur: 8'h23};
`ifdef BORDER_REPLICATE_EN
    first_exp = '{ul: 8'h00, up: 8'h00, left: 8'h00, cur: 8'h00};
    c10_exp   = '{ul: 8'h00, up: 8'h00, left: 8'h10, cur: 8'h10};
    tests++;
    if (n !== 12) begin fails++; $display("FAIL %s_count: %0d windows required 12", tag, n); end
    got = (n > 4) ? cap[4] : 32'hxxxxxxxx;
    tests++;
    if (got !== c10_exp) begin fails++; $display("FAIL %s_pix10: %h required %h", tag, got, c10_exp); end
`else
    first_exp = '{ul: 8'h00, up: 8'h01, left: 8'h10, cur: 8'h11};
    c10_exp   = '0;
    tests++;
    if (n !== 6) begin fails++; $display("FAIL %s_count: %0d windows required 6 (c10=%h)", tag, n, c10_exp); end
`endif
    got = (n > 0) ? cap[0] : 32'hxxxxxxxx;
    tests++;
    if (got !== first_exp) begin fails++; $display("FAIL %s_first: %h required %h", tag, got, first_exp); end
    got = (n > 0) ? cap[n-1] : 32'hxxxxxxxx;
    tests++;
    if (got !== last_exp) begin fails++; $display("FAIL %s_last: %h required %h", tag, got, last_exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({out_valid, busy, done, err_cfg, in_ready, out_last, out_row_par, out_col_par} !== 8'h00 ||
        out_win !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: valid=%0b busy=%0b done=%0b err=%0b rdy=%0b win=%h required all 0",
               out_valid, busy, done, err_cfg, in_ready, out_win);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    fill_pattern(4, 3);
    run_frame(4, 3, 1'b0, 1'b0, n);
    check_4x3(n, "basic");
  endtask

  task automatic test_backpressure();
    int n;
    fill_pattern(4, 3);
    run_frame(4, 3, 1'b1, 1'b1, n);
    check_4x3(n, "stall");
    tests++;
    if (err_cfg !== 1'b0) begin fails++; $display("FAIL busy_start_ignored: err_cfg=%0b required 0", err_cfg); end
  endtask

  task automatic test_bad_cfg();
    int ws [3] = '{1, 5, MAX_W+1};
    int hs [3] = '{5, 1, 2};
    bit bad;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      image_width = DIM_W'(ws[t]); image_height = DIM_W'(hs[t]);
      start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      @(negedge clk);
      start = 1'b0;
      #1;
      tests++;
      if (err_cfg !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL bad_cfg_%0d: err=%0b busy=%0b rdy=%0b valid=%0b required err=1 busy=0 rdy=0 valid=0",
                 t, err_cfg, busy, in_ready, out_valid);
      end
      bad = 0;
      repeat (5) begin
        @(negedge clk);
        if (done !== 1'b0 || out_valid !== 1'b0 || err_cfg !== 1'b1) bad = 1;
      end
      tests++;
      if (bad) begin fails++; $display("FAIL bad_cfg_quiet_%0d: activity seen, required err held and no done", t); end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int pix, n;
    bit bad;
    fill_pattern(8, 8);
    @(negedge clk);
    image_width = DIM_W'(8); image_height = DIM_W'(8); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix = 0;
    for (int c = 0; c < 100 && pix < 12; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = frame[pix]; out_ready = 1'b1;
      #1;
      if (in_ready) pix++;
    end
    tests++;
    if (pix != 12) begin fails++; $display("FAIL midframe_feed: %0d pixels required 12", pix); end
    // Leave the pixel at (1,4) offered and hit reset.
    @(negedge clk);
    in_data = frame[12]; rst = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL reset_mid: outputs active during reset, required idle"); end
    rst = 1'b0; in_valid = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL post_reset_idle: output or done seen, required none"); end
    fill_pattern(4, 3);
    run_frame(4, 3, 1'b0, 1'b0, n);
    check_4x3(n, "after_rst");
  endtask

  task automatic test_max_width();
    int n;
    logic [31:0] got;
    for (int i = 0; i < 2*MAX_W; i++) frame[i] = 8'($urandom_range(0, 255));
    run_frame(MAX_W, 2, 1'b0, 1'b0, n);
    tests++;
    if (n !== (BORDER ? 2*MAX_W : MAX_W-1)) begin
      fails++;
      $display("FAIL maxw_count: %0d windows required %0d", n, BORDER ? 2*MAX_W : MAX_W-1);
    end
`ifndef BORDER_REPLICATE_EN
    for (int k = 0; k < n; k++) begin
      got = cap[k];
      tests++;
      if (got[23:16] !== frame[k+1]) begin
        fails++;
        $display("FAIL maxw_up_%0d: up=%h required %h", k, got[23:16], frame[k+1]);
      end
    end
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; image_width = '0; image_height = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_cfg();
    test_reset_mid();
    test_max_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
